cim_controller: RTL and testbench

CIM_CONTROLLER -- requirements
Module: cim_controller

---
 rtl/cim_controller.sv | 182 ++++++++++++++++++
 tb/tb_cim_controller.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_controller.sv
// cim_controller: command-to-macro sequencer for a compute-in-memory array.
// Accepts WRITE / COMPUTE / READ_OUT / READ_MEM commands one at a time,
// drives registered strobes to the CIM macro and returns read data through
// a valid/ready response channel.
module cim_controller #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_acc,
  input  logic [3:0]        cmd_sel,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  // macro side
  output logic              cim_cs,
  output logic              cim_web,
  output logic              cim_cimeb,
  output logic              cim_psum_eb,
  output logic              cim_reset_out,
  output logic [3:0]        cim_output_reg,
  output logic [ADDR_W-1:0] cim_address,
  output logic [DATA_W-1:0] cim_input_data,
  input  logic [DATA_W-1:0] cim_mem_output,
  input  logic [DATA_W-1:0] cim_cim_output
);

  localparam logic [1:0] OP_WRITE    = 2'b00;
  localparam logic [1:0] OP_COMPUTE  = 2'b01;
  localparam logic [1:0] OP_READ_OUT = 2'b10;
  localparam logic [1:0] OP_READ_MEM = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    CLR,
    CMP,
    RD_ISSUE,
    RD_WAIT,
    RSP
  } state_t;

  state_t state;

  // Command fields captured at accept; later cmd_* activity cannot disturb
  // the operation in flight.
  logic [1:0]        lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic accept;

  // The macro is word addressed: byte offset bits are always cleared.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    word_align = addr & ~ADDR_W'(3);
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Capture the command payload on the accept edge (datapath, no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_op   <= cmd_op;
      lat_addr <= cmd_addr;
      lat_data <= cmd_data;
    end
  end

  // Sequencer: state, macro strobes and response registers. Every macro
  // output falls back to its idle level each cycle unless the next state
  // needs a strobe, so each strobe is exactly one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cim_cs         <= 1'b0;
      cim_web        <= 1'b0;
      cim_cimeb      <= 1'b1;
      cim_psum_eb    <= 1'b0;
      cim_reset_out  <= 1'b0;
      cim_output_reg <= '0;
      cim_address    <= '0;
      cim_input_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
    end else begin
      cim_cs         <= 1'b0;
      cim_web        <= 1'b0;
      cim_cimeb      <= 1'b1;
      cim_psum_eb    <= 1'b0;
      cim_reset_out  <= 1'b0;
      cim_output_reg <= '0;
      cim_address    <= '0;
      cim_input_data <= '0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WRITE: begin
                state          <= WR;
                cim_cs         <= 1'b1;
                cim_web        <= 1'b1;
                cim_address    <= word_align(cmd_addr);
                cim_input_data <= cmd_data;
              end
              OP_COMPUTE: begin
                if (cmd_acc) begin
                  state          <= CMP;
                  cim_cs         <= 1'b1;
                  cim_cimeb      <= 1'b0;
                  cim_psum_eb    <= 1'b1;
                  cim_address    <= word_align(cmd_addr);
                  cim_input_data <= cmd_data;
                end else begin
                  // Clear the output registers before a fresh compute.
                  state         <= CLR;
                  cim_reset_out <= 1'b1;
                end
              end
              OP_READ_OUT: begin
                state          <= RD_ISSUE;
                cim_cs         <= 1'b1;
                cim_output_reg <= cmd_sel;
              end
              OP_READ_MEM: begin
                state       <= RD_ISSUE;
                cim_cs      <= 1'b1;
                cim_address <= word_align(cmd_addr);
              end
              default: state <= IDLE;
            endcase
          end
        end

        WR: state <= IDLE;

        CLR: begin
          state          <= CMP;
          cim_cs         <= 1'b1;
          cim_cimeb      <= 1'b0;
          cim_psum_eb    <= 1'b1;
          cim_address    <= word_align(lat_addr);
          cim_input_data <= lat_data;
        end

        CMP: state <= IDLE;

        // The macro samples the read strobe at the end of RD_ISSUE and
        // presents its result during the following cycle.
        RD_ISSUE: state <= RD_WAIT;

        RD_WAIT: begin
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_data  <= (lat_op == OP_READ_MEM) ? cim_mem_output : cim_cim_output;
        end

        // rsp_data is left untouched here so it stays stable until consumed.
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_controller.sv
// tb_cim_controller: drives directed and random commands into cim_controller,
// models the CIM macro at pin level and keeps a command-level reference of
// memory and output registers to predict every read result and strobe.
module tb_cim_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_acc = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;
  logic        cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_reset_out;
  logic [3:0]  cim_output_reg;
  logic [31:0] cim_address, cim_input_data;
  logic [31:0] cim_mem_output, cim_cim_output;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_WRITE    = 2'b00;
  localparam logic [1:0] OP_COMPUTE  = 2'b01;
  localparam logic [1:0] OP_READ_OUT = 2'b10;
  localparam logic [1:0] OP_READ_MEM = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        acc;
    logic [3:0]  sel;
    logic [7:0]  hold;
  } cmd_t;

  cim_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .cmd_acc        (cmd_acc),
    .cmd_sel        (cmd_sel),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .cim_cs         (cim_cs),
    .cim_web        (cim_web),
    .cim_cimeb      (cim_cimeb),
    .cim_psum_eb    (cim_psum_eb),
    .cim_reset_out  (cim_reset_out),
    .cim_output_reg (cim_output_reg),
    .cim_address    (cim_address),
    .cim_input_data (cim_input_data),
    .cim_mem_output (cim_mem_output),
    .cim_cim_output (cim_cim_output)
  );

  always #5 clk = ~clk;

  // Initial macro memory: word i holds bytes 4i-4 .. 4i-1 (word 1 = 00010203).
  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(4 * i - 4);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  // Contribution of one compute to output register j.
  function automatic logic [31:0] mac_term(input int j, input logic [31:0] x, input logic [31:0] w);
    return (x & w) + 32'(j);
  endfunction

  // ---------------- pin-level macro model ----------------
  logic [31:0] mem [256];
  logic [31:0] outr [16];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    for (int j = 0; j < 16; j++) outr[j] = '0;
  end

  always @(posedge clk) begin
    if (cim_cs && cim_web) mem[cim_address[9:2]] <= cim_input_data;
    if (cim_reset_out)
      for (int j = 0; j < 16; j++) outr[j] <= '0;
    if (cim_cs && !cim_web && !cim_cimeb && cim_psum_eb)
      for (int j = 0; j < 16; j++)
        outr[j] <= outr[j] + mac_term(j, cim_input_data, mem[cim_address[9:2]]);
    if (cim_cs && !cim_web && cim_cimeb) begin
      cim_mem_output <= mem[cim_address[9:2]];
      cim_cim_output <= outr[cim_output_reg];
    end else begin
      // Outside the valid window the macro outputs are junk.
      cim_mem_output <= $urandom;
      cim_cim_output <= $urandom;
    end
  end

  // ---------------- command-level reference ----------------
  logic [31:0] ref_mem [256];
  logic [31:0] ref_out [16];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int j = 0; j < 16; j++) ref_out[j] = '0;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pin_exp(input logic cs, input logic web, input logic cimeb,
                                           input logic psum, input logic rst, input logic [3:0] oreg,
                                           input logic [31:0] addr, input logic [31:0] data);
    return {55'b0, cs, web, cimeb, psum, rst, oreg, addr, data};
  endfunction

  function automatic logic [127:0] pins_now();
    return {55'b0, cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_reset_out,
            cim_output_reg, cim_address, cim_input_data};
  endfunction

  function automatic logic [127:0] idle_pins();
    return pin_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endfunction

  // {busy, cmd_ready, rsp_valid}
  function automatic logic [127:0] ctl_exp(input logic b, input logic r, input logic v);
    return {125'b0, b, r, v};
  endfunction

  function automatic logic [127:0] ctl_now();
    return {125'b0, busy, cmd_ready, rsp_valid};
  endfunction

  function automatic logic [127:0] d32(input logic [31:0] x);
    return {96'b0, x};
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op   = 2'($urandom);
    c.addr = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
    c.data = $urandom;
    c.acc  = 1'($urandom);
    c.sel  = 4'($urandom);
    c.hold = 8'($urandom_range(0, 3));
    return c;
  endfunction

  task automatic present(input cmd_t c);
    cmd_valid = 1'b1;
    cmd_op    = c.op;
    cmd_addr  = c.addr;
    cmd_data  = c.data;
    cmd_acc   = c.acc;
    cmd_sel   = c.sel;
  endtask

  task automatic scramble();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = $urandom;
    cmd_data  = $urandom;
    cmd_acc   = 1'($urandom);
    cmd_sel   = 4'($urandom);
  endtask

  // Called at a negedge with the command presented; returns at the negedge
  // just before the accepting rising edge.
  task automatic await_accept();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("accept_timeout", {127'b0, cmd_ready}, 128'd1);
  endtask

  // Checks every cycle of one accepted command, updating the reference.
  // b2b keeps cmd_valid high with the next command during this one.
  task automatic follow(input cmd_t c, input bit b2b, input cmd_t nxt, input bit rst_mid);
    logic [31:0] a;
    logic [31:0] exp_rd;
    int idx;
    a   = c.addr & ~32'h3;
    idx = int'(c.addr[9:2]);
    @(negedge clk);
    if (b2b) present(nxt);
    else scramble();
    case (c.op)
      OP_WRITE: begin
        check("wr_strobe", pins_now(), pin_exp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, a, c.data));
        check("wr_ctl", ctl_now(), ctl_exp(1'b1, 1'b0, 1'b0));
        ref_mem[idx] = c.data;
        @(negedge clk);
        check("wr_done_pins", pins_now(), idle_pins());
        check("wr_done_ctl", ctl_now(), ctl_exp(1'b0, 1'b1, 1'b0));
      end
      OP_COMPUTE: begin
        if (!c.acc) begin
          check("clr_pulse", pins_now(), pin_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0));
          check("clr_ctl", ctl_now(), ctl_exp(1'b1, 1'b0, 1'b0));
          for (int j = 0; j < 16; j++) ref_out[j] = '0;
          @(negedge clk);
        end
        check("cmp_strobe", pins_now(), pin_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, a, c.data));
        check("cmp_ctl", ctl_now(), ctl_exp(1'b1, 1'b0, 1'b0));
        for (int j = 0; j < 16; j++) ref_out[j] = ref_out[j] + mac_term(j, c.data, ref_mem[idx]);
        @(negedge clk);
        check("cmp_done_pins", pins_now(), idle_pins());
        check("cmp_done_ctl", ctl_now(), ctl_exp(1'b0, 1'b1, 1'b0));
      end
      default: begin
        if (c.op == OP_READ_MEM) begin
          exp_rd = ref_mem[idx];
          check("rdm_issue", pins_now(), pin_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, a, 32'h0));
        end else begin
          exp_rd = ref_out[c.sel];
          check("rdo_issue", pins_now(), pin_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, c.sel, 32'h0, 32'h0));
        end
        check("rd_issue_ctl", ctl_now(), ctl_exp(1'b1, 1'b0, 1'b0));
        @(negedge clk);
        check("rd_wait_pins", pins_now(), idle_pins());
        check("rd_wait_ctl", ctl_now(), ctl_exp(1'b1, 1'b0, 1'b0));
        if (rst_mid) begin
          rst_n = 1'b0;
          #1;
          check("rst_async_pins", pins_now(), idle_pins());
          check("rst_async_busy", {127'b0, busy}, 128'd0);
          check("rst_async_valid", {127'b0, rsp_valid}, 128'd0);
          check("rst_async_data", d32(rsp_data), d32(32'h0));
          @(negedge clk);
          check("rst_hold_pins", pins_now(), idle_pins());
          check("rst_hold_valid", {127'b0, rsp_valid}, 128'd0);
          rst_n = 1'b1;
          @(negedge clk);
          check("rst_rel_ctl", ctl_now(), ctl_exp(1'b0, 1'b1, 1'b0));
          check("rst_rel_pins", pins_now(), idle_pins());
          check("rst_rel_data", d32(rsp_data), d32(32'h0));
        end else begin
          @(negedge clk);
          check("rsp_ctl", ctl_now(), ctl_exp(1'b1, 1'b0, 1'b1));
          check("rsp_data", d32(rsp_data), d32(exp_rd));
          for (int i = 0; i < int'(c.hold); i++) begin
            @(negedge clk);
            check("rsp_hold_ctl", ctl_now(), ctl_exp(1'b1, 1'b0, 1'b1));
            check("rsp_hold_data", d32(rsp_data), d32(exp_rd));
          end
          rsp_ready = 1'b1;
          @(negedge clk);
          rsp_ready = 1'b0;
          check("rsp_done_ctl", ctl_now(), ctl_exp(1'b0, 1'b1, 1'b0));
          check("rsp_done_pins", pins_now(), idle_pins());
        end
      end
    endcase
  endtask

  task automatic run(input cmd_t c);
    cmd_t none;
    none = '0;
    present(c);
    await_accept();
    follow(c, 1'b0, none, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cmd_t c, c2, none, cur, nxt;
    bit b2b, pending;
    logic [31:0] wa [8];
    wa = '{32'd0, 32'd4, 32'd128, 32'd132, 32'd256, 32'd260, 32'd384, 32'd388};
    none = '0;

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pins", pins_now(), idle_pins());
    check("reset_busy", {127'b0, busy}, 128'd0);
    check("reset_valid", {127'b0, rsp_valid}, 128'd0);
    check("reset_data", d32(rsp_data), d32(32'h0));
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_rel_ctl", ctl_now(), ctl_exp(1'b0, 1'b1, 1'b0));

    // READ_MEM addr 6 -> word address 4, initial contents 00010203
    c = '0; c.op = OP_READ_MEM; c.addr = 32'd6;
    run(c);

    // single WRITE
    c = '0; c.op = OP_WRITE; c.addr = 32'd128; c.data = 32'h07060504;
    run(c);

    // eight WRITEs then a clearing COMPUTE
    for (int i = 0; i < 8; i++) begin
      c = '0; c.op = OP_WRITE; c.addr = wa[i]; c.data = $urandom;
      run(c);
    end
    c = '0; c.op = OP_COMPUTE; c.acc = 1'b0; c.data = 32'h88888888;
    run(c);

    // READ_OUT sel 5 with a stalled consumer
    c = '0; c.op = OP_READ_OUT; c.sel = 4'd5; c.hold = 8'd4;
    run(c);

    // two accumulating COMPUTEs with cmd_valid held throughout
    c  = '0; c.op  = OP_COMPUTE; c.acc  = 1'b1; c.addr  = 32'd4;   c.data  = 32'h12345678;
    c2 = '0; c2.op = OP_COMPUTE; c2.acc = 1'b1; c2.addr = 32'd132; c2.data = 32'h0F0F0F0F;
    present(c);
    await_accept();
    follow(c, 1'b1, c2, 1'b0);
    await_accept();
    follow(c2, 1'b0, none, 1'b0);

    // reset pulse while a read waits on the macro
    c = '0; c.op = OP_READ_OUT; c.sel = 4'd3;
    present(c);
    await_accept();
    follow(c, 1'b0, none, 1'b1);
    c = '0; c.op = OP_READ_OUT; c.sel = 4'd3;
    run(c);

    // random traffic, sometimes back-to-back
    cur = rand_cmd();
    pending = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (!pending) present(cur);
      await_accept();
      nxt = rand_cmd();
      b2b = 1'($urandom);
      follow(cur, b2b, nxt, 1'b0);
      cur = nxt;
      pending = b2b;
    end
    if (pending) begin
      await_accept();
      follow(cur, 1'b0, none, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
